apb_rr_master: RTL and testbench

- Two-requester APB master: round-robin arbitration between two simple req/ack ports and generation of the APB SETUP/ACCESS sequence.
- Decodes address into a 16-bit one-hot PSEL, which also drives the select input of the PRDATA read mux.
- Completes each transfer with a one-cycle ACK carrying read data and an error flag.
- Sits between the bus-side requesters (CPU bridge, DMA) and the APB slave fabric.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_addr_decode.sv | 21 ++
 rtl/apb_rr_master.sv | 155 +++++++++++++++
 tb/tb_apb_rr_master.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master slice.
//   apb_state_t   : transfer sequencer states (IDLE -> SETUP -> ACCESS -> RESP)
//   APB_BASE_DEF  : default value of address bits [31:16] for a mapped access
//   SLV_*/BASE_*  : bit positions of the slave field and base field in an address
//   TO_W          : width of the ACCESS wait counter (holds TIMEOUT values up to 255)
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam logic [15:0] APB_BASE_DEF = 16'h4000;

  localparam int SLV_LSB  = 12;
  localparam int SLV_MSB  = 15;
  localparam int BASE_LSB = 16;
  localparam int BASE_MSB = 31;

  localparam int TO_W = 8;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB address decoder.
//   addr   in  32  byte address
//   sel    out 16  one-hot slave select (all zero when the address is unmapped)
//   mapped out 1   address[31:16] matches BASE
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [15:0] BASE = APB_BASE_DEF
) (
  input  logic [31:0] addr,
  output logic [15:0] sel,
  output logic        mapped
);

  always_comb begin
    mapped = (addr[BASE_MSB:BASE_LSB] == BASE);
    sel    = '0;
    if (mapped) sel[addr[SLV_MSB:SLV_LSB]] = 1'b1;
  end

endmodule

// File: rtl/apb_rr_master.sv
// Two-requester APB master with round-robin arbitration.
//   PCLK, PRESET              clock, asynchronous active-high reset
//   REQx/WRITEx/ADDRx/WDATAx  requester ports (held stable until ACKx)
//   ACK0, ACK1, RDATA, ERR    one-cycle completion pulse with read data / error
//   PADDR/PWRITE/PWDATA/PSEL/PENABLE, PRDATA/PREADY/PSLVERR  APB bus
//   dbg_state                 current sequencer state (apb_state_t encoding)
//
// Requester handshake: REQx is raised with its command fields and held until
// ACKx pulses; REQx must be low in the cycle after ACKx or a new transfer
// starts. ACK0 and ACK1 are never high together.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter logic [15:0] APB_BASE = APB_BASE_DEF,
  parameter int          TIMEOUT  = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WRITE0,
  input  logic        WRITE1,
  input  logic [31:0] ADDR0,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  output logic        ACK0,
  output logic        ACK1,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [15:0] PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic [1:0]  dbg_state
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  apb_state_t      state;
  logic            last;      // requester that won the most recent contention
  logic            owner;
  logic            mapped_q;
  logic [TO_W-1:0] cnt;

  logic        nxt_owner;
  logic [31:0] nxt_addr;
  logic [15:0] nxt_sel;
  logic        nxt_mapped;

  logic        acc_done;
  logic [31:0] acc_rdata;
  logic        acc_err;

  assign dbg_state = state;

  // Owner chosen in IDLE: a lone requester wins outright, contention goes to
  // the requester that did not win last time.
  always_comb begin
    nxt_owner = (REQ0 && REQ1) ? ~last : REQ1;
    nxt_addr  = nxt_owner ? ADDR1 : ADDR0;
  end

  // Decoding the address as it is latched lets PSEL be a register that is
  // already valid in SETUP; the registered read mux needs that extra cycle.
  apb_addr_decode #(.BASE(APB_BASE)) u_decode (
    .addr   (nxt_addr),
    .sel    (nxt_sel),
    .mapped (nxt_mapped)
  );

  // ACCESS completion. An unmapped access ends at once (PREADY reads as 1);
  // a real PREADY beats a timeout that falls on the same cycle.
  always_comb begin
    acc_done  = 1'b0;
    acc_rdata = '0;
    acc_err   = 1'b0;
    if (!mapped_q) begin
      acc_done  = 1'b1;
      acc_rdata = PRDATA;
      acc_err   = 1'b1;
    end else if (PREADY) begin
      acc_done  = 1'b1;
      acc_rdata = PWRITE ? '0 : PRDATA;
      acc_err   = PSLVERR;
    end else if (cnt == TO_LAST) begin
      acc_done  = 1'b1;
      acc_rdata = '0;
      acc_err   = 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      mapped_q <= 1'b0;
      cnt      <= '0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      RDATA    <= '0;
      ERR      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            owner    <= nxt_owner;
            if (REQ0 && REQ1) last <= nxt_owner;
            PADDR    <= nxt_addr;
            PWRITE   <= nxt_owner ? WRITE1 : WRITE0;
            PWDATA   <= nxt_owner ? WDATA1 : WDATA0;
            PSEL     <= nxt_sel;
            mapped_q <= nxt_mapped;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (acc_done) begin
            RDATA   <= acc_rdata;
            ERR     <= acc_err;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ACK0    <= ~owner;
            ACK1    <= owner;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ACK0  <= 1'b0;
          ACK1  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed scenarios plus random single transfers,
// with a small APB slave (registered read mux, programmable wait states).
module tb_apb_rr_master;

  localparam int TIMEOUT = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        REQ0, REQ1, WRITE0, WRITE1;
  logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
  logic        ACK0, ACK1, ERR, PWRITE, PENABLE;
  logic [31:0] RDATA, PADDR, PWDATA, PRDATA;
  logic [15:0] PSEL;
  logic        PREADY, PSLVERR;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int last_m   = 1;

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  apb_rr_master #(.APB_BASE(16'h4000), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ0(REQ0), .REQ1(REQ1), .WRITE0(WRITE0), .WRITE1(WRITE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .ERR(ERR),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state(dbg_state)
  );

  // ---------------- slave model ----------------
  logic [31:0] slave_data [16];
  logic [31:0] nomap_data;
  logic [15:0] sel_q;
  int          wait_n;
  int          wait_cnt;

  always @(posedge PCLK or posedge PRESET)
    if (PRESET) sel_q <= '0;
    else        sel_q <= PSEL;

  always @(posedge PCLK or posedge PRESET)
    if (PRESET)                 wait_cnt <= 0;
    else if (PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
    else if (!PENABLE)          wait_cnt <= 0;

  always_comb begin
    PRDATA = nomap_data;
    for (int i = 0; i < 16; i++) if (sel_q[i]) PRDATA = slave_data[i];
  end

  always_comb PREADY = PENABLE && (wait_cnt >= wait_n);

  // ---------------- reference model ----------------
  function automatic logic [15:0] exp_sel(input logic [31:0] a);
    if (a[31:16] == 16'h4000) return 16'(1) << a[15:12];
    return 16'h0000;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_req(input int r, input logic v);
    if (r == 0) REQ0 = v; else REQ1 = v;
  endtask

  task automatic drive_cmd(input int r, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    if (r == 0) begin WRITE0 = wr; ADDR0 = a; WDATA0 = wd; end
    else        begin WRITE1 = wr; ADDR1 = a; WDATA1 = wd; end
  endtask

  // One transfer from an idle DUT; called at the negedge of an IDLE cycle.
  task automatic xfer(input string name, input int r, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input int waits, input logic serr);
    logic [15:0] es;
    int          acc_n, ack_at, ack_seen;
    logic [31:0] erd;
    logic        eerr, bad_phase;
    logic [1:0]  exp_ack;
    es = exp_sel(addr);
    if (es == 16'h0)         begin acc_n = 1;         erd = nomap_data; eerr = 1'b1; end
    else if (waits < TIMEOUT) begin acc_n = waits + 1; erd = wr ? 32'h0 : slave_data[addr[15:12]]; eerr = serr; end
    else                     begin acc_n = TIMEOUT;   erd = 32'h0;      eerr = 1'b1; end
    ack_at  = acc_n + 2;
    exp_ack = (r == 0) ? 2'b01 : 2'b10;
    wait_n  = waits;
    PSLVERR = serr;
    drive_cmd(r, wr, addr, wd);
    set_req(r, 1'b1);
    ack_seen  = -1;
    bad_phase = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge PCLK);
      if (ACK0 || ACK1) begin ack_seen = k; break; end
      if (k == 1) begin
        n_checks++;
        if (PSEL !== es || PENABLE !== 1'b0) begin
          n_err++;
          $display("FAIL %s setup: got psel=%h penable=%b expected psel=%h penable=0", name, PSEL, PENABLE, es);
        end
        n_checks++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wd) begin
          n_err++;
          $display("FAIL %s apb_cmd: got %h/%b/%h expected %h/%b/%h", name, PADDR, PWRITE, PWDATA, addr, wr, wd);
        end
      end else if (PSEL !== es || PENABLE !== 1'b1) bad_phase = 1'b1;
    end
    n_checks++;
    if (ack_seen != ack_at) begin
      n_err++;
      $display("FAIL %s ack_cycle: got %0d expected %0d", name, ack_seen, ack_at);
    end
    n_checks++;
    if (bad_phase) begin
      n_err++;
      $display("FAIL %s access_phase: got unstable psel/penable expected psel=%h penable=1", name, es);
    end
    n_checks++;
    if ({ACK1, ACK0} !== exp_ack) begin
      n_err++;
      $display("FAIL %s ack_owner: got %b expected %b", name, {ACK1, ACK0}, exp_ack);
    end
    n_checks++;
    if (RDATA !== erd || ERR !== eerr) begin
      n_err++;
      $display("FAIL %s resp: got rdata=%h err=%b expected rdata=%h err=%b", name, RDATA, ERR, erd, eerr);
    end
    n_checks++;
    if (PSEL !== 16'h0 || PENABLE !== 1'b0) begin
      n_err++;
      $display("FAIL %s resp_bus: got psel=%h penable=%b expected 0/0", name, PSEL, PENABLE);
    end
    set_req(r, 1'b0);
    @(negedge PCLK);
    n_checks++;
    if ({ACK1, ACK0} !== 2'b00) begin
      n_err++;
      $display("FAIL %s ack_pulse: got %b expected 00", name, {ACK1, ACK0});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    PRESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    drive_cmd(0, 1'b0, 32'h0, 32'h0);
    drive_cmd(1, 1'b0, 32'h0, 32'h0);
    PSLVERR = 1'b0;
    wait_n  = 0;
    repeat (3) @(negedge PCLK);
    n_checks++;
    if ({ACK0, ACK1, ERR, PWRITE, PENABLE} !== 5'b0 || PSEL !== 16'h0) begin
      n_err++;
      $display("FAIL reset_ctrl: got ack=%b%b err=%b pwrite=%b penable=%b psel=%h expected all 0",
               ACK1, ACK0, ERR, PWRITE, PENABLE, PSEL);
    end
    n_checks++;
    if (RDATA !== 32'h0 || PADDR !== 32'h0 || PWDATA !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: got rdata=%h paddr=%h pwdata=%h expected 0", RDATA, PADDR, PWDATA);
    end
    PRESET = 1'b0;
    last_m = 1;
    @(negedge PCLK);
  endtask

  task automatic test_read_basic();
    slave_data[3] = 32'hA5A5_0003;
    xfer("read_basic", 0, 1'b0, 32'h4000_3004, 32'h0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [0:0]  exp_q[$];
    logic [0:0]  g;
    int          done_n[2];
    int          hold[2];
    logic [31:0] wd[2];
    logic        dual;
    int          w;
    w = (last_m == 1) ? 0 : 1;
    last_m = w;
    exp_q.push_back(1'(w)); exp_q.push_back(1'(1 - w));
    exp_q.push_back(1'(w)); exp_q.push_back(1'(1 - w));
    wait_n = 0; PSLVERR = 1'b0; dual = 1'b0;
    done_n[0] = 0; done_n[1] = 0; hold[0] = 0; hold[1] = 0;
    wd[0] = $urandom; wd[1] = $urandom;
    drive_cmd(0, 1'b1, 32'h4000_1000, wd[0]);
    drive_cmd(1, 1'b1, 32'h4000_2000, wd[1]);
    REQ0 = 1'b1; REQ1 = 1'b1;
    for (int cyc = 0; cyc < 200 && (done_n[0] < 2 || done_n[1] < 2); cyc++) begin
      @(negedge PCLK);
      if (ACK0 && ACK1) dual = 1'b1;
      for (int r = 0; r < 2; r++) begin
        if ((r == 0) ? ACK0 : ACK1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL b2b_grant: got extra ack from %0d expected none", r);
          end else begin
            g = exp_q.pop_front();
            if (int'(g) != r) begin
              n_err++;
              $display("FAIL b2b_grant: got %0d expected %0d", r, g);
            end
          end
          n_checks++;
          if (PWDATA !== wd[r] || RDATA !== 32'h0 || ERR !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_data: got pwdata=%h rdata=%h err=%b expected %h/0/0", PWDATA, RDATA, ERR, wd[r]);
          end
          done_n[r]++;
          set_req(r, 1'b0);
          hold[r] = (done_n[r] < 2) ? 2 : 0;
        end else if (hold[r] > 0) begin
          hold[r]--;
          if (hold[r] == 0) begin
            wd[r] = $urandom;
            drive_cmd(r, 1'b1, (r == 0) ? 32'h4000_1000 : 32'h4000_2000, wd[r]);
            set_req(r, 1'b1);
          end
        end
      end
    end
    n_checks++;
    if (done_n[0] != 2 || done_n[1] != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: got %0d/%0d acks expected 2/2", done_n[0], done_n[1]);
    end
    n_checks++;
    if (dual) begin
      n_err++;
      $display("FAIL b2b_dual_ack: got both acks in one cycle expected never");
    end
    @(negedge PCLK);
  endtask

  task automatic test_wait_err();
    xfer("wait_err", 1, 1'b1, 32'h4000_F000, 32'h1234_5678, 3, 1'b1);
  endtask

  task automatic test_unmapped();
    nomap_data = 32'hDEAD_BEEF;
    xfer("unmapped", 0, 1'b0, 32'h5000_0000, 32'h0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    slave_data[7] = $urandom;
    xfer("timeout_abort", 0, 1'b0, 32'h4000_7010, 32'h0, 255, 1'b0);
    xfer("timeout_edge", 1, 1'b0, 32'h4000_7010, 32'h0, TIMEOUT - 1, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid();
    wait_n = 1000;
    drive_cmd(1, 1'b0, 32'h4000_2000, 32'h0);
    REQ1 = 1'b1;
    repeat (3) @(negedge PCLK);
    n_checks++;
    if (PENABLE !== 1'b1 || PSEL !== 16'h0004) begin
      n_err++;
      $display("FAIL rst_mid_pre: got penable=%b psel=%h expected 1/0004", PENABLE, PSEL);
    end
    #2 PRESET = 1'b1;
    #1;
    n_checks++;
    if (PSEL !== 16'h0 || PENABLE !== 1'b0 || {ACK1, ACK0} !== 2'b00 || PADDR !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_async: got psel=%h penable=%b ack=%b paddr=%h expected 0",
               PSEL, PENABLE, {ACK1, ACK0}, PADDR);
    end
    REQ1 = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    last_m = 1;
    wait_n = 0;
    @(negedge PCLK);
    slave_data[9] = $urandom;
    xfer("post_reset", 1, 1'b0, 32'h4000_9000, 32'h0, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) != 0) a = {16'h4000, 4'($urandom_range(0, 15)), 12'($urandom)};
      else                           a = {16'h4001 + 16'($urandom_range(0, 100)), 16'($urandom)};
      nomap_data = $urandom;
      xfer("random", $urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom,
           $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 16; i++) slave_data[i] = $urandom;
    nomap_data = 32'h0BAD_0BAD;
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_wait_err();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
